// File: rtl/timestamp_mem_loader.sv
// timestamp_mem_loader: writes the host stream into every shadow frame group, then requests a bank swap
module timestamp_mem_loader #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 17,
   parameter int GRP_W   = 3,
   parameter int MAX_GRP = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic              clk_i,
   input  logic              nrst_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [ADDR_W-1:0] last_addr_i,
   input  logic [GRP_W-1:0]  number_of_frames_i,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic              update_mem_i,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              wen_o,
   output logic [GRP_W-1:0]  memory_selector_o,
   output logic              mem_updated_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] last_addr, addr;
   logic [GRP_W-1:0]  frames, grp;
   logic [TW-1:0]     tcnt;
   logic              upd_ref;
   logic              hs;

   assign s_ready_o = state == LOAD;
   assign busy_o    = state != IDLE;
   assign hs        = s_valid_i & s_ready_o;

   always_ff @(posedge clk_i or negedge nrst_i)
      if (!nrst_i) begin
         state             <= IDLE;
         last_addr         <= '0;
         addr              <= '0;
         frames            <= '0;
         grp               <= '0;
         tcnt              <= '0;
         upd_ref           <= 1'b0;
         waddr_o           <= '0;
         wdata_o           <= '0;
         wen_o             <= 1'b0;
         memory_selector_o <= '0;
         mem_updated_o     <= 1'b0;
         done_o            <= 1'b0;
         err_o             <= 1'b0;
      end else begin
         wen_o  <= 1'b0;
         done_o <= 1'b0;
         if (abort_i) begin
            state         <= IDLE;
            mem_updated_o <= 1'b0;
         end else
            case (state)
               IDLE:
                  if (start_i) begin
                     state     <= LOAD;
                     last_addr <= last_addr_i;
                     frames    <= (number_of_frames_i > GRP_W'(MAX_GRP)) ? GRP_W'(MAX_GRP) : number_of_frames_i;
                     addr      <= '0;
                     grp       <= '0;
                     err_o     <= 1'b0;
                  end
               LOAD:
                  if (hs) begin
                     wen_o             <= 1'b1;
                     waddr_o           <= addr;
                     wdata_o           <= s_data_i;
                     memory_selector_o <= grp;
                     addr              <= (addr == last_addr) ? '0 : addr + 1'b1;
                     if (addr == last_addr) begin
                        // last word of the last group: the swap reference is the bank select seen now
                        if (grp == frames) begin
                           state   <= COMMIT;
                           upd_ref <= update_mem_i;
                           tcnt    <= '0;
                        end else
                           grp <= grp + 1'b1;
                     end
                  end
               COMMIT:
                  if (update_mem_i != upd_ref) begin
                     state         <= IDLE;
                     mem_updated_o <= 1'b0;
                     done_o        <= 1'b1;
                  end else if (tcnt == TW'(TIMEOUT - 1)) begin
                     state         <= IDLE;
                     mem_updated_o <= 1'b0;
                     err_o         <= 1'b1;
                  end else begin
                     tcnt          <= tcnt + 1'b1;
                     mem_updated_o <= 1'b1;
                  end
               default: state <= IDLE;
            endcase
      end
endmodule
